// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction encodings, fetch FSM states, default widths.
package cpu_pkg;
  localparam int              PC_W_DEF     = 8;
  localparam int              INSTR_W_DEF  = 16;
  localparam logic [7:0]      JUMPR_PREFIX = 8'h9A;
  localparam logic [15:0]     NOP          = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next.sv
// Next-PC computation: sequential increment or PC-relative JUMPR target.
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    next_pc,
  output logic               is_jumpr
);
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_off;

  assign is_jumpr = (instr[15:8] == JUMPR_PREFIX);
  assign w_seq    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  // 8-bit displacement is signed, relative to the following instruction
  assign w_off    = PC_W'($signed(instr[7:0]));
  assign next_pc  = is_jumpr ? (w_seq + w_off) : w_seq;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, drives ROM address, fills the IF/ID register with valid/ready.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [15:0]        fetch_count
);
  fetch_state_e      r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, r_ir_pc;
  logic [INSTR_W-1:0] r_ir;
  logic              r_ir_valid;
  logic [15:0]       r_cnt;
  logic [PC_W-1:0]   w_next_pc;
  logic              w_jumpr_unused;  // decode consumes is_jumpr; fetch only needs the target
  logic              w_slot_free;
  logic              w_fetch;

  pc_next #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_pc_next (
    .pc       (r_pc),
    .instr    (instr),
    .next_pc  (w_next_pc),
    .is_jumpr (w_jumpr_unused)
  );

  assign w_slot_free = !r_ir_valid || ir_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    case (r_state)
      IDLE:    if (run) w_state_nxt = FETCH;
      FETCH: begin
        if (!run)             w_state_nxt = IDLE;
        else if (w_slot_free) w_fetch     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    // redirect freezes the FSM and suppresses the fetch
    if (redirect) begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= NOP;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_pc       <= redirect_pc;
        r_ir_valid <= 1'b0;
      end else if (w_fetch) begin
        r_ir       <= instr;
        r_ir_pc    <= r_pc;
        r_ir_valid <= 1'b1;
        r_pc       <= w_next_pc;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end else if (w_slot_free) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign pc          = r_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign fetch_count = r_cnt;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that acts as the initiator on the instruction-ROM interface. It owns the program counter, drives the ROM address, and captures the returned 16-bit word into an IF/ID register with a valid/ready handshake toward decode. PC-relative jumps (JUMPR) are resolved locally in the fetch cycle. Redirects from later pipeline stages override everything else.

## Interface
Parameters:
- PC_W, 8, program counter / ROM address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- run  in  1  fetch enable; fetching advances only while high
- pc  out  PC_W  ROM address (registered PC)
- instr  in  INSTR_W  ROM data; combinational function of pc, valid in the same cycle
- ir  out  INSTR_W  fetched instruction to decode
- ir_pc  out  PC_W  address that ir was fetched from
- ir_valid  out  1  ir holds an instruction not yet accepted
- ir_ready  in  1  decode accepts ir on a cycle where ir_valid=1 and ir_ready=1
- redirect  in  1  flush and reload PC from a later stage
- redirect_pc  in  PC_W  redirect target
- fetch_count  out  16  number of fetches since reset, saturating

## Operation
- Reset values: pc=RESET_PC, ir=16'h0000, ir_pc=0, ir_valid=0, fetch_count=0, state=IDLE.
- States:
  - IDLE: no fetch. Moves to FETCH on a cycle where run=1.
  - FETCH: fetches when the slot is free. Moves to IDLE on a cycle where run=0, with no fetch in that cycle.
- Slot free = !ir_valid || ir_ready.
- Fetch, in FETCH with the slot free and redirect=0:
  - ir<=instr, ir_pc<=pc, ir_valid<=1.
  - pc<=next_pc.
  - fetch_count increments, saturating at 16'hFFFF.
- Slot not free (stall): pc, ir, ir_pc and ir_valid hold. The ROM output stays stable.
- Slot free with no fetch (IDLE, or run=0): ir_valid<=0 once the held word is accepted.
- next_pc:
  - JUMPR (instr[15:8]==8'h9A): pc + 1 + sign_extend(instr[7:0]), modulo 2^PC_W.
  - Otherwise: pc + 1, modulo 2^PC_W, so 8'hFF wraps to 8'h00.
- A JUMPR word is forwarded on ir unchanged.
- redirect=1 has highest priority, in any state and whatever ir_ready is:
  - pc<=redirect_pc, ir_valid<=0 (the held word is discarded), no fetch that cycle.
  - fetch_count unchanged.
  - State is unchanged.
- run falling while ir_valid=1: the held word remains until accepted or redirected.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). After rst_n rises, the first fetch is from RESET_PC.

## Timing
- pc→instr is combinational. ir/ir_valid are registered and appear one cycle after the fetch edge.
- Throughput is 1 instruction per cycle with ir_ready held high.
- JUMPR costs zero bubbles: the target is fetched on the cycle after the JUMPR fetch.
- Redirect costs one bubble: redirect in cycle N, ir_valid=0 in N+1, target word valid in N+2 if run=1.
- IDLE→FETCH: run rising in cycle N gives the first fetch at the end of cycle N+1, so ir_valid=1 in N+2.
- Decode must not assume ir changes while ir_valid=1 and ir_ready=0.

## Structure
- Shared package `cpu_pkg`:
  - JUMPR_PREFIX=8'h9A, NOP=16'h0000
  - fetch state enum {IDLE, FETCH}
  - PC_W/INSTR_W defaults
- One sub-module: `pc_next`, purely combinational (pc, instr → next_pc, is_jumpr). Decode reuses it for jump identification.
- Everything else (state, IF/ID register, counter) stays in instr_fetch.

## Test plan
- ROM {0:16'hA208, 1:16'hAA00, 2:16'h9AFD}, run=1, ir_ready=1 → ir_pc sequence 0,1,2,0,1,2 with ir 16'hA208,16'hAA00,16'h9AFD,16'hA208; no bubbles; fetch_count=6 after six fetches.
- JUMPR 16'h9AEE at pc 8'h11 → next fetched ir_pc=8'h00.
- ir_ready=0 for 3 cycles while ir_valid=1 → ir, ir_pc and pc frozen, fetch_count unchanged; release → sequence resumes with no word lost or duplicated.
- redirect=1 with redirect_pc=8'h40 in the same cycle a JUMPR is presented, ir_ready=0 → ir_valid=0 next cycle, then ir_pc=8'h40; the JUMPR target is never fetched.
- Linear code at pc 8'hFE → ir_pc 8'hFE, 8'hFF, 8'h00.
- rst_n low mid-stream (ir_valid=1, pc=8'h05) → ir_valid=0 and pc=RESET_PC without waiting for a clock; after release with run=1, first ir_pc=8'h00.
